// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared state encoding, instruction field positions and opcode helpers
package instr_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam int B_BIT     = 31;
    localparam int C_BIT     = 30;
    localparam int WE_BIT    = 29;
    localparam int WS_MSB    = 28;
    localparam int WS_LSB    = 27;
    localparam int ALUOP_MSB = 26;
    localparam int ALUOP_LSB = 23;
    localparam int RA1_MSB   = 22;
    localparam int RA1_LSB   = 18;
    localparam int RA2_MSB   = 17;
    localparam int RA2_LSB   = 13;
    localparam int WA_MSB    = 12;
    localparam int WA_LSB    = 8;
    localparam int CONST_MSB = 7;
    localparam int CONST_LSB = 0;

    // B and C together are not a branch; that encoding is reserved for HALT.
    function automatic logic is_halt(input logic [31:0] ir);
        return ir[B_BIT] & ir[C_BIT];
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - next-PC selection between sequential and word-scaled branch target
module pc_next_calc (
    input  logic [31:0] pc,
    input  logic        b,
    input  logic        c,
    input  logic        comp,
    input  logic [7:0]  imm,
    output logic [31:0] pc_next
);

    logic [31:0] offset;
    logic        taken;

    always_comb begin
        offset  = {{22{imm[7]}}, imm, 2'b00};
        taken   = b | (c & comp);
        pc_next = taken ? (pc + offset) : (pc + 32'd4);
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/exec/writeback control FSM with run, step and fetch timeout
module instr_sequencer
    import instr_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        step_mode_i,
    input  logic        step_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        comp_i,
    output logic [3:0]  alu_op_o,
    output logic [4:0]  ra1_o,
    output logic [4:0]  ra2_o,
    output logic [4:0]  wa_o,
    output logic [1:0]  ws_o,
    output logic [7:0]  const_o,
    output logic        rf_we_o,
    output logic [31:0] pc_o,
    output logic        halted_o,
    output logic        timeout_err_o,
    output logic [31:0] instr_count_o
);

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        comp_q;
    logic [7:0]  tmo_cnt;
    logic        timeout_err;
    logic [31:0] instr_count;
    logic        req_q;
    logic        we_q;
    logic        halted_q;
    logic [31:0] pc_next;

    pc_next_calc u_pc_next (
        .pc      (pc),
        .b       (ir[B_BIT]),
        .c       (ir[C_BIT]),
        .comp    (comp_q),
        .imm     (ir[CONST_MSB:CONST_LSB]),
        .pc_next (pc_next)
    );

    // req/we/halted are registered alongside every state transition so they
    // always agree with the state they describe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= 32'd0;
            comp_q      <= 1'b0;
            tmo_cnt     <= 8'd0;
            timeout_err <= 1'b0;
            instr_count <= 32'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_i && (!step_mode_i || step_i)) begin
                        state   <= S_FETCH;
                        req_q   <= 1'b1;
                        tmo_cnt <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        ir      <= imem_rdata_i;
                        state   <= S_EXEC;
                        req_q   <= 1'b0;
                        tmo_cnt <= 8'd0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_HALT;
                        req_q       <= 1'b0;
                        halted_q    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    comp_q <= comp_i;
                    if (is_halt(ir)) begin
                        state    <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state <= S_WB;
                        we_q  <= ir[WE_BIT];
                    end
                end
                S_WB: begin
                    pc          <= pc_next;
                    instr_count <= instr_count + 32'd1;
                    if (run_i && !step_mode_i) begin
                        state   <= S_FETCH;
                        req_q   <= 1'b1;
                        tmo_cnt <= 8'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    req_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc;
    assign pc_o          = pc;
    assign rf_we_o       = we_q;
    assign halted_o      = halted_q;
    assign timeout_err_o = timeout_err;
    assign instr_count_o = instr_count;
    assign alu_op_o      = ir[ALUOP_MSB:ALUOP_LSB];
    assign ra1_o         = ir[RA1_MSB:RA1_LSB];
    assign ra2_o         = ir[RA2_MSB:RA2_LSB];
    assign wa_o          = ir[WA_MSB:WA_LSB];
    assign ws_o          = ir[WS_MSB:WS_LSB];
    assign const_o       = ir[CONST_MSB:CONST_LSB];

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer against an instruction-level model
module tb_instr_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        run_i;
    logic        step_mode_i;
    logic        step_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        comp_i;
    logic [3:0]  alu_op_o;
    logic [4:0]  ra1_o;
    logic [4:0]  ra2_o;
    logic [4:0]  wa_o;
    logic [1:0]  ws_o;
    logic [7:0]  const_o;
    logic        rf_we_o;
    logic [31:0] pc_o;
    logic        halted_o;
    logic        timeout_err_o;
    logic [31:0] instr_count_o;

    always #5 clk_i = ~clk_i;

    instr_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (15)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (run_i),
        .step_mode_i   (step_mode_i),
        .step_i        (step_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .comp_i        (comp_i),
        .alu_op_o      (alu_op_o),
        .ra1_o         (ra1_o),
        .ra2_o         (ra2_o),
        .wa_o          (wa_o),
        .ws_o          (ws_o),
        .const_o       (const_o),
        .rf_we_o       (rf_we_o),
        .pc_o          (pc_o),
        .halted_o      (halted_o),
        .timeout_err_o (timeout_err_o),
        .instr_count_o (instr_count_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b0;
        run_i        = 1'b0;
        step_mode_i  = 1'b0;
        step_i       = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'd0;
        comp_i       = 1'b0;
        repeat (2) tick();
        rst_i   = 1'b1;
        m_pc    = 32'd0;
        m_count = 32'd0;
    endtask

    // Fetch, execute and retire one instruction, checking the DUT against the
    // instruction-level model at each phase boundary.
    task automatic exec_one(input logic [31:0] w, input logic cmp, input int lat,
                            input bit b2b, input bit step_pulse, input bit drop_run);
        int waited;
        int offs;
        waited = 0;
        while (!imem_req_o && waited < 20) begin
            tick();
            waited++;
        end
        chk("req_seen", 32'(imem_req_o), 32'd1);
        if (!imem_req_o) return;
        if (b2b) chk("back_to_back", 32'(waited), 32'd0);
        chk("fetch_addr", imem_addr_o, m_pc);
        for (int i = 0; i < lat; i++) begin
            step_i = step_pulse && (i == 0);
            tick();
        end
        step_i       = 1'b0;
        imem_rdata_i = w;
        imem_ack_i   = 1'b1;
        tick();
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
        chk("req_in_exec", 32'(imem_req_o), 32'd0);
        chk("decode", {3'd0, alu_op_o, ra1_o, ra2_o, wa_o, ws_o, const_o},
            {3'd0, w[26:23], w[22:18], w[17:13], w[12:8], w[28:27], w[7:0]});
        comp_i = cmp;
        if (drop_run) run_i = 1'b0;
        tick();
        comp_i = 1'($urandom);
        if (w[31] && w[30]) begin
            chk("halt_flag", 32'(halted_o), 32'd1);
            chk("halt_pc", pc_o, m_pc);
            chk("halt_count", instr_count_o, m_count);
            chk("halt_we", 32'(rf_we_o), 32'd0);
            return;
        end
        chk("wb_we", 32'(rf_we_o), 32'(w[29]));
        tick();
        offs = int'($signed(w[7:0])) * 4;
        if (w[31] || (w[30] && cmp)) m_pc = m_pc + 32'(offs);
        else                         m_pc = m_pc + 32'd4;
        m_count = m_count + 32'd1;
        chk("retire_pc", pc_o, m_pc);
        chk("retire_count", instr_count_o, m_count);
        chk("we_one_cycle", 32'(rf_we_o), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] pc_before;
        bit          b2b;
        bit          drop;
        int          n_req;

        do_reset();
        rst_i = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_out_lo", {26'd0, rf_we_o, halted_o, timeout_err_o, 3'd0}, 32'd0);
        chk("rst_count", instr_count_o, 32'd0);
        chk("rst_decode", {3'd0, alu_op_o, ra1_o, ra2_o, wa_o, ws_o, const_o}, 32'd0);
        rst_i = 1'b1;

        // sequential flow, zero-wait acks
        run_i = 1'b1;
        exec_one(32'h2000_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        exec_one(32'h2000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("seq_addr", imem_addr_o, 32'h8);
        chk("seq_count", instr_count_o, 32'd2);

        // unconditional branches, backward and forward
        exec_one(32'h0000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        exec_one(32'h0000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("at_0x10", pc_o, 32'h10);
        exec_one(32'h8000_00FE, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("br_back", pc_o, 32'h8);
        do_reset();
        run_i = 1'b1;
        exec_one(32'h8000_007F, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("br_fwd", pc_o, 32'h1FC);

        // conditional branches
        pc_before = pc_o;
        exec_one(32'h6000_0003, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        chk("cond_taken", pc_o, pc_before + 32'd12);
        pc_before = pc_o;
        exec_one(32'h4000_0003, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        chk("cond_not_taken", pc_o, pc_before + 32'd4);

        // random program with random ack latency and run_i drops
        b2b = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            if (w[31] && w[30]) w[30] = 1'b0;
            drop = ($urandom_range(0, 4) == 0);
            exec_one(w, 1'($urandom), $urandom_range(0, 6), b2b, 1'b0, drop);
            if (drop) begin
                repeat (3) tick();
                chk("idle_after_run_drop", 32'(imem_req_o), 32'd0);
                chk("idle_pc", pc_o, m_pc);
                run_i = 1'b1;
                b2b   = 1'b0;
            end else begin
                b2b = 1'b1;
            end
        end

        // HALT freezes everything until reset
        exec_one(32'hC000_0000, 1'b0, 0, b2b, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            run_i       = 1'($urandom);
            step_mode_i = 1'($urandom);
            step_i      = 1'($urandom);
            imem_ack_i  = 1'($urandom);
            tick();
        end
        step_i     = 1'b0;
        imem_ack_i = 1'b0;
        chk("halt_stays", 32'(halted_o), 32'd1);
        chk("halt_no_req", 32'(imem_req_o), 32'd0);
        chk("halt_pc_frozen", pc_o, m_pc);
        chk("halt_count_frozen", instr_count_o, m_count);

        // fetch timeout
        do_reset();
        run_i = 1'b1;
        n_req = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (imem_req_o) n_req++;
        end
        chk("tmo_req_cycles", 32'(n_req), 32'd15);
        chk("tmo_err", 32'(timeout_err_o), 32'd1);
        chk("tmo_halted", 32'(halted_o), 32'd1);
        chk("tmo_req_low", 32'(imem_req_o), 32'd0);
        chk("tmo_pc", pc_o, 32'd0);

        // single-step: three pulses, one of them ignored during FETCH
        do_reset();
        run_i       = 1'b1;
        step_mode_i = 1'b1;
        repeat (3) tick();
        chk("step_wait_idle", 32'(imem_req_o), 32'd0);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        exec_one(32'h2000_0000, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        repeat (4) tick();
        chk("step_rest1", 32'(imem_req_o), 32'd0);
        step_i = 1'b1;
        tick();
        step_i = 1'b0;
        exec_one(32'h0000_0000, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        chk("step_rest2", 32'(imem_req_o), 32'd0);
        chk("step_count", instr_count_o, 32'd2);

        // asynchronous reset in the middle of a fetch
        do_reset();
        run_i = 1'b1;
        exec_one(32'h0000_0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk("mid_fetch_req", 32'(imem_req_o), 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req_o), 32'd0);
        chk("async_pc", pc_o, 32'd0);
        chk("async_count", instr_count_o, 32'd0);
        run_i        = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'h2000_0000;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (2) tick();
        imem_ack_i = 1'b0;
        chk("late_ack_req", 32'(imem_req_o), 32'd0);
        chk("late_ack_count", instr_count_o, 32'd0);
        chk("late_ack_decode", {3'd0, alu_op_o, ra1_o, ra2_o, wa_o, ws_o, const_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM for the single-issue datapath (PC, instruction memory, register file, ALU). It fetches through a req/ack handshake, latches the instruction, and drives the decode fields to the RF/ALU. It also generates the RF write strobe and updates the PC for sequential, unconditional and conditional flow. Run, single-step, halt and fetch-timeout control support board bring-up with switches and HEX display.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 15, max cycles waiting for imem_ack_i before fault (1..255)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-low reset
run_i  in  1  level; 1 = execute, 0 = stop at next instruction boundary
step_mode_i  in  1  1 = execute one instruction per step_i pulse
step_i  in  1  single-cycle pulse, honoured only in IDLE with step_mode_i=1
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (= pc_o)
imem_ack_i  in  1  fetch data valid this cycle
imem_rdata_i  in  32  instruction word
comp_i  in  1  ALU comparison result for current decode fields
alu_op_o  out  4  IR[26:23]
ra1_o  out  5  IR[22:18]
ra2_o  out  5  IR[17:13]
wa_o  out  5  IR[12:8]
ws_o  out  2  IR[28:27], write-data select
const_o  out  8  IR[7:0]
rf_we_o  out  1  RF write strobe, one cycle in WB
pc_o  out  32  current PC
halted_o  out  1  FSM in HALT
timeout_err_o  out  1  sticky fetch-timeout flag
instr_count_o  out  32  retired-instruction counter

Behaviour:
- Instruction format: IR[31]=B (unconditional branch), IR[30]=C (conditional branch), IR[29]=WE (register write), IR[28:27]=WS, fields as listed in Ports. B=1 with C=1 is the HALT opcode.
- Reset (rst_i=0, asynchronous): state=IDLE, PC=RESET_PC, IR=0, instr_count=0, timeout_err=0, timeout counter=0. All outputs go low except pc_o/imem_addr_o=RESET_PC.
- IDLE: leave for FETCH when run_i=1 and (step_mode_i=0 or step_i=1). Otherwise stay in IDLE.
- FETCH: imem_req_o=1 every cycle until ack. On the imem_ack_i=1 edge, IR<=imem_rdata_i and go to EXEC. A zero-wait ack (ack in the first req cycle) is legal. The timeout counter increments each FETCH cycle without ack. When it reaches FETCH_TIMEOUT, set timeout_err<=1 and go to HALT; the PC is unchanged.
- EXEC: one cycle. Decode outputs are stable from IR, and comp_i is sampled at the end of the cycle. A HALT opcode goes to HALT with PC, count and rf_we unchanged. Any other opcode goes to WB.
- WB: one cycle. rf_we_o=IR[29]. The PC updates at the end of the cycle:
  - B=1: PC + ({{22{c[7]}},c,2'b00})
  - C=1 and comp_latched=1: same target
  - otherwise: PC+4
  - All PC arithmetic is modulo 2^32 (wrap-around, no fault).
  - instr_count increments in WB, wrapping at 2^32.
  - Next state is FETCH if run_i=1 and step_mode_i=0, else IDLE.
- HALT: terminal state. Only rst_i exits. halted_o=1.
- Decode outputs hold IR contents in every state, including between instructions.
- imem_req_o is high only in FETCH. rf_we_o is high only in WB.
- Minimum throughput is 3 cycles per instruction (FETCH, EXEC, WB).
- step_i pulses outside IDLE are ignored, not queued.
- run_i falling mid-instruction: the instruction completes, then the FSM enters IDLE.
- A reset asserted mid-FETCH drops imem_req_o immediately (asynchronous). Any late ack is ignored because the state is IDLE.

Decomposition:
- Shared package instr_pkg holds:
  - state encoding localparams S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT;
  - field bit positions (B_BIT=31, C_BIT=30, WE_BIT=29, WS_MSB/LSB, ALUOP/RA1/RA2/WA/CONST ranges);
  - HALT opcode predicate.
- One natural sub-module: pc_next_calc, a combinational next-PC/branch-target calculator (inputs PC, B, C, comp, const; output next PC).

Test Plan:
1. Reset release with run_i=1, ack in the first req cycle, memory words 0x2000_0000 at 0x0 and 0x2000_0000 at 0x4 -> imem_addr_o sequence 0x0, 0x4, 0x8; one instruction per 3 cycles; instr_count_o=2 after 6 cycles.
2. At PC=0x10, B=1, const=8'hFE -> next fetch address 0x08. At PC=0x0, B=1, const=8'h7F -> 0x1FC.
3. C=1, const=8'h03: comp_i=1 -> PC+12; comp_i=0 -> PC+4. rf_we_o=1 for exactly one cycle when IR[29]=1, and 0 when IR[29]=0.
4. Word 0xC000_0000 fetched -> halted_o=1 after EXEC; PC and instr_count frozen; further run_i/step_i have no effect until reset.
5. imem_ack_i held low with FETCH_TIMEOUT=15 -> after 15 req cycles timeout_err_o=1, halted_o=1, imem_req_o=0.
6. step_mode_i=1 with three step_i pulses, one of them issued during FETCH -> exactly two instructions retire (instr_count_o=2) and the FSM rests in IDLE. Reset mid-FETCH -> imem_req_o=0 in the same cycle and pc_o=RESET_PC.
